// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//               pipeline registers and the PC of a 5-stage pipeline.
//               - load-use hazard detection (stall IF/ID + PC, bubble ID/EX)
//               - flush of younger stages on a taken branch resolved in MEM
//               - pipeline freeze while a multi-cycle data access completes
//               - sticky data-memory timeout error
//               - saturating stall / flush statistics counters
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_TIMEOUT : max MEM_WAIT cycles before entering TIMEOUT (>= 2)
//   CNT_W       : width of stallCount / flushCount
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   idRs, idRt, idUsesRt: source registers of the instruction in ID
//   exMemRead, exRt     : load in EX and its destination register
//   memBranch, memZero  : branch control / condition of the instruction in MEM
//   memMemRead/Write    : data-memory operation of the instruction in MEM
//   dmemReady           : data memory completes the access this cycle
//   pcWrite, pcSrc      : PC load enable, PC takes branch target
//   ifIdWrite/ifIdFlush : IF/ID load enable, IF/ID -> NOP
//   idExFlush/exMemFlush: bubble ID/EX, EX/MEM control
//   pipeEn              : load enable for ID/EX, EX/MEM, MEM/WB
//   dmemReq             : data memory request
//   memTimeout          : sticky timeout error
//   stallCount          : cycles with pcWrite=0 (RUN / MEM_WAIT only)
//   flushCount          : taken branches
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             memBranch,
    input  logic [31:0]      memZero,
    input  logic             memMemRead,
    input  logic             memMemWrite,
    input  logic             dmemReady,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             exMemFlush,
    output logic             pipeEn,
    output logic             dmemReq,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0]    r_stallCount;
    logic [CNT_W-1:0]    r_flushCount;

    logic w_memOp;
    logic w_taken;
    logic w_loadUse;
    logic w_waitClr;
    logic w_waitInc;
    logic w_flushInc;
    logic w_stallInc;

    assign w_memOp   = memMemRead | memMemWrite;
    assign w_taken   = memBranch & (|memZero);
    // r0 is hard-wired zero, so a load "to r0" never creates a dependency.
    assign w_loadUse = exMemRead & (exRt != 5'd0) &
                       ((exRt == idRs) | (idUsesRt & (exRt == idRt)));

    // ------------------------------------------------------------------
    // State register, wait counter and statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_waitCnt    <= '0;
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_waitClr) begin
                r_waitCnt <= '0;
            end else if (w_waitInc) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            // Statistics saturate at all-ones instead of wrapping.
            if (w_stallInc && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (w_flushInc && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

    assign stallCount = r_stallCount;
    assign flushCount = r_flushCount;

    // ------------------------------------------------------------------
    // Next-state and control outputs (combinational, 0-cycle latency)
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_waitClr   = 1'b0;
        w_waitInc   = 1'b0;
        w_flushInc  = 1'b0;
        pcWrite     = 1'b1;
        pcSrc       = 1'b0;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        exMemFlush  = 1'b0;
        pipeEn      = 1'b1;
        dmemReq     = w_memOp;
        memTimeout  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_memOp && !dmemReady) begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    pipeEn      = 1'b0;
                    dmemReq     = 1'b1;
                    w_waitClr   = 1'b1;
                    w_nextState = ST_MEM_WAIT;
                end else if (w_taken) begin
                    // A taken branch squashes the younger instructions, so a
                    // load-use hazard among them is irrelevant.
                    pcSrc      = 1'b1;
                    ifIdFlush  = 1'b1;
                    idExFlush  = 1'b1;
                    exMemFlush = 1'b1;
                    w_flushInc = 1'b1;
                end else if (w_loadUse) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    idExFlush = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                dmemReq = 1'b1;
                if (dmemReady) begin
                    w_nextState = ST_RUN;
                    if (w_taken) begin
                        pcSrc      = 1'b1;
                        ifIdFlush  = 1'b1;
                        idExFlush  = 1'b1;
                        exMemFlush = 1'b1;
                        w_flushInc = 1'b1;
                    end else if (w_loadUse) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExFlush = 1'b1;
                    end
                end else begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    pipeEn    = 1'b0;
                    w_waitInc = 1'b1;
                    if (r_waitCnt == c_WAIT_LAST) begin
                        w_nextState = ST_TIMEOUT;
                    end
                end
            end

            ST_TIMEOUT: begin
                // Terminal error state: pipeline frozen until reset.
                memTimeout = 1'b1;
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                pipeEn     = 1'b0;
                dmemReq    = 1'b0;
            end

            default: begin
                w_nextState = ST_RUN;
            end
        endcase

        // Stall statistics only cover live operation, never the error state.
        w_stallInc = (r_state != ST_TIMEOUT) && !pcWrite;

        // Outputs drop as soon as reset asserts, not at the next edge.
        if (!rst_n) begin
            pcWrite    = 1'b0;
            pcSrc      = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b0;
            idExFlush  = 1'b0;
            exMemFlush = 1'b0;
            pipeEn     = 1'b0;
            dmemReq    = 1'b0;
            memTimeout = 1'b0;
            w_stallInc = 1'b0;
            w_flushInc = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
//               A second instance with CNT_W=2 exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  idRs, idRt, exRt;
    logic        idUsesRt, exMemRead, memBranch, memMemRead, memMemWrite, dmemReady;
    logic [31:0] memZero;

    logic        pcWrite, pcSrc, ifIdWrite, ifIdFlush, idExFlush, exMemFlush;
    logic        pipeEn, dmemReq, memTimeout;
    logic [15:0] stallCount, flushCount;

    logic        pcWrite2, pcSrc2, ifIdWrite2, ifIdFlush2, idExFlush2, exMemFlush2;
    logic        pipeEn2, dmemReq2, memTimeout2;
    logic [1:0]  stallCount2, flushCount2;

    int nChecks = 0;
    int nFails  = 0;

    // Control vector order:
    // pcWrite pcSrc ifIdWrite ifIdFlush idExFlush exMemFlush pipeEn dmemReq memTimeout
    logic [8:0] ctl, ctl2;
    assign ctl  = {pcWrite, pcSrc, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
                   pipeEn, dmemReq, memTimeout};
    assign ctl2 = {pcWrite2, pcSrc2, ifIdWrite2, ifIdFlush2, idExFlush2, exMemFlush2,
                   pipeEn2, dmemReq2, memTimeout2};

    localparam logic [8:0] c_CTL_RESET   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] c_CTL_RUN     = 9'b1_0_1_0_0_0_1_0_0;
    localparam logic [8:0] c_CTL_LDUSE   = 9'b0_0_0_0_1_0_1_0_0;
    localparam logic [8:0] c_CTL_TAKEN   = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] c_CTL_MSTALL  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] c_CTL_MREADY  = 9'b1_0_1_0_0_0_1_1_0;
    localparam logic [8:0] c_CTL_MTAKEN  = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] c_CTL_TIMEOUT = 9'b0_0_0_0_0_0_0_0_1;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .memBranch(memBranch), .memZero(memZero),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite), .dmemReady(dmemReady),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExFlush(idExFlush), .exMemFlush(exMemFlush), .pipeEn(pipeEn),
        .dmemReq(dmemReq), .memTimeout(memTimeout),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exRt(exRt), .memBranch(memBranch), .memZero(memZero),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite), .dmemReady(dmemReady),
        .pcWrite(pcWrite2), .pcSrc(pcSrc2), .ifIdWrite(ifIdWrite2), .ifIdFlush(ifIdFlush2),
        .idExFlush(idExFlush2), .exMemFlush(exMemFlush2), .pipeEn(pipeEn2),
        .dmemReq(dmemReq2), .memTimeout(memTimeout2),
        .stallCount(stallCount2), .flushCount(flushCount2)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0; exMemRead = 1'b0; exRt = 5'd0;
        memBranch = 1'b0; memZero = 32'd0; memMemRead = 1'b0; memMemWrite = 1'b0;
        dmemReady = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        rst_n = 1'b0;
        memMemRead = 1'b1;             // a pending access must not request during reset
        #2;
        checkEq("reset_ctl", 32'(ctl), 32'(c_CTL_RESET));
        checkEq("reset_stall", 32'(stallCount), 32'd0);
        checkEq("reset_flush", 32'(flushCount), 32'd0);
        @(negedge clk);
        setIdle();
        rst_n = 1'b1;
        #1;
        checkEq("run_idle_ctl", 32'(ctl), 32'(c_CTL_RUN));
        tick();

        // T1: load-use on rs, then exRt=0, then rt with/without idUsesRt
        exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
        #1 checkEq("t1_lduse_rs_ctl", 32'(ctl), 32'(c_CTL_LDUSE));
        tick();
        checkEq("t1_stall_1", 32'(stallCount), 32'd1);
        exRt = 5'd0; idRs = 5'd0;
        #1 checkEq("t1_r0_ctl", 32'(ctl), 32'(c_CTL_RUN));
        tick();
        checkEq("t1_stall_still1", 32'(stallCount), 32'd1);
        idRs = 5'd3; idRt = 5'd7; exRt = 5'd7; idUsesRt = 1'b1;
        #1 checkEq("t1_lduse_rt_ctl", 32'(ctl), 32'(c_CTL_LDUSE));
        tick();
        checkEq("t1_stall_2", 32'(stallCount), 32'd2);
        idUsesRt = 1'b0;
        #1 checkEq("t1_rt_unused_ctl", 32'(ctl), 32'(c_CTL_RUN));
        tick();
        checkEq("t1_stall_still2", 32'(stallCount), 32'd2);

        // T2: taken branch overrides load-use
        setIdle();
        exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
        memBranch = 1'b1; memZero = 32'h1;
        #1 checkEq("t2_taken_ctl", 32'(ctl), 32'(c_CTL_TAKEN));
        tick();
        checkEq("t2_flush_1", 32'(flushCount), 32'd1);
        checkEq("t2_stall_same", 32'(stallCount), 32'd2);
        setIdle();
        memBranch = 1'b1; memZero = 32'h0;
        #1 checkEq("t2_not_taken_ctl", 32'(ctl), 32'(c_CTL_RUN));
        tick();
        checkEq("t2_flush_still1", 32'(flushCount), 32'd1);

        // memOp already ready in RUN: no wait, branch handled same cycle
        setIdle();
        memMemRead = 1'b1; dmemReady = 1'b1; memBranch = 1'b1; memZero = 32'h8000_0000;
        #1 checkEq("run_ready_taken_ctl", 32'(ctl), 32'(c_CTL_MTAKEN));
        tick();
        checkEq("run_ready_flush_2", 32'(flushCount), 32'd2);
        setIdle();
        #1 checkEq("run_ready_no_wait", 32'(ctl), 32'(c_CTL_RUN));

        // T3: three not-ready cycles then ready
        memMemRead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checkEq($sformatf("t3_wait_c%0d", i), 32'(ctl), 32'(c_CTL_MSTALL));
            tick();
        end
        dmemReady = 1'b1;
        #1 checkEq("t3_ready_c3", 32'(ctl), 32'(c_CTL_MREADY));
        tick();
        setIdle();
        #1 checkEq("t3_back_run", 32'(ctl), 32'(c_CTL_RUN));
        checkEq("t3_stall_5", 32'(stallCount), 32'd5);

        // T4: never ready -> TIMEOUT after 1 RUN + 16 MEM_WAIT cycles
        memMemWrite = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1 checkEq($sformatf("t4_wait_c%0d", i), 32'(ctl), 32'(c_CTL_MSTALL));
            tick();
        end
        #1 checkEq("t4_timeout_ctl", 32'(ctl), 32'(c_CTL_TIMEOUT));
        checkEq("t4_stall_22", 32'(stallCount), 32'd22);
        dmemReady = 1'b1; memBranch = 1'b1; memZero = 32'h1;
        #1 checkEq("t4_timeout_sticky_ctl", 32'(ctl), 32'(c_CTL_TIMEOUT));
        tick();
        tick();
        checkEq("t4_timeout_held", 32'(ctl), 32'(c_CTL_TIMEOUT));
        checkEq("t4_stall_frozen", 32'(stallCount), 32'd22);
        checkEq("t4_flush_frozen", 32'(flushCount), 32'd2);

        // T5: reset in the 2nd MEM_WAIT cycle
        #2 rst_n = 1'b0;
        #1 checkEq("t5_rst_from_timeout", 32'(ctl), 32'(c_CTL_RESET));
        #1 rst_n = 1'b1;
        setIdle();
        tick();
        memMemRead = 1'b1;
        tick();
        tick();
        checkEq("t5_memwait2_req", 32'(ctl), 32'(c_CTL_MSTALL));
        #2 rst_n = 1'b0;
        #1;
        checkEq("t5_rst_ctl", 32'(ctl), 32'(c_CTL_RESET));
        checkEq("t5_rst_stall", 32'(stallCount), 32'd0);
        checkEq("t5_rst_flush", 32'(flushCount), 32'd0);
        setIdle();
        #1 rst_n = 1'b1;
        #1 checkEq("t5_after_rst_run", 32'(ctl), 32'(c_CTL_RUN));
        tick();

        // T6: saturation of the 2-bit counters
        memBranch = 1'b1; memZero = 32'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkEq($sformatf("t6_flush2_%0d", i), 32'(flushCount2), (i < 3) ? i + 1 : 3);
            checkEq($sformatf("t6_flush16_%0d", i), 32'(flushCount), i + 1);
        end
        setIdle();
        exMemRead = 1'b1; exRt = 5'd9; idRs = 5'd9;
        #1 checkEq("t6_sat_ctl", 32'(ctl2), 32'(c_CTL_LDUSE));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkEq($sformatf("t6_stall2_%0d", i), 32'(stallCount2), (i < 3) ? i + 1 : 3);
        end
        checkEq("t6_stall16", 32'(stallCount), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
